uart_frame_assembler: RTL and testbench
=======================================

// Module: uart_frame_assembler
// PURPOSE
//  Packs the UART receive byte stream into fixed-layout frames for the coprocessor.
//  Frame length is a runtime value capped by a parameter.
//  An inter-byte timeout discards partial frames so a lost byte cannot skew later frames.
//  Completed frames sit in a one-deep output buffer with a valid/ready handshake.
//  Sits between uart_top's rx side and the coprocessor din/din_valid pair.
// PARAMETERS
//  DBITS          8        bits per UART character
//  FRAME_BYTES    16       maximum bytes per frame; output width FRAME_BYTES*DBITS
//  TIMEOUT_CYCLES 1000000  idle clk cycles mid-frame before abort; 0 disables timeout
//  CNT_W          8        width of byte counter/frame_len; must hold FRAME_BYTES
// PORTS
//  clk          in   1                 single system clock
//  rst_n        in   1                 async assert, active-low reset
//  byte_in      in   DBITS             received character
//  byte_valid   in   1                 1-cycle strobe: byte_in valid
//  frame_len    in   CNT_W             bytes per frame, sampled on first byte; 0 or >FRAME_BYTES -> FRAME_BYTES
//  frame_out    out  FRAME_BYTES*DBITS assembled frame; byte k at [k*DBITS +: DBITS]
//  frame_valid  out  1                 output buffer holds a frame
//  frame_ready  in   1                 consumer accepts frame when valid&ready
//  byte_count   out  CNT_W             bytes collected in the current partial frame
//  overrun      out  1                 sticky: a completed frame was dropped
//  timeout_err  out  1                 sticky: a partial frame was aborted
//  clr_err      in   1                 sync clear of both sticky flags
// BEHAVIOUR
//  - Reset state: all outputs 0, collect buffer 0, FSM IDLE.
//  - FSM IDLE: on byte_valid, latch the clamped length L and store the byte at slot 0.
//    Go to DONE if L==1, else go to COLLECT.
//  - FSM COLLECT: each byte_valid writes slot byte_count and increments byte_count.
//    Writing slot L-1 moves to DONE.
//  - FSM DONE (1 cycle): zero slots >= L, then move the collect buffer to the output buffer.
//    Return to IDLE; byte_count returns to 0.
//  - Latency: frame_valid rises 2 clk after the strobe of the last byte.
//  - Handshake: frame_out/frame_valid stay stable while valid & !ready.
//    A transfer happens on a rising clk with valid & ready; valid drops next cycle unless a new frame loads.
//  - DONE with output buffer empty, or buffer draining the same cycle (valid&ready): load, frame_valid=1.
//  - DONE with buffer full and !ready: drop the new frame, keep the old one, set overrun.
//  - byte_valid during DONE: treated as the first byte of the next frame (IDLE path), never lost.
//  - Timeout counter: cleared on every byte_valid and in IDLE; counts in COLLECT only.
//  - Timeout reaching TIMEOUT_CYCLES-1 with no byte that cycle: discard the partial frame, set timeout_err, go to IDLE.
//  - Timeout and byte_valid in the same cycle: the byte wins and the counter restarts.
//  - clr_err and a flag-setting event in the same cycle: set wins.
//  - Changes to frame_len mid-frame are ignored until the next first byte.
//  - rst_n low at any time (mid-frame, mid-handshake) clears immediately; no partial frame survives.
// STRUCTURE
//  - Shared package uart_pkg: state encoding localparams (IDLE/COLLECT/DONE) and the DBITS default.
//  - One sub-module, frame_out_buf: the one-deep valid/ready register stage, reusable on the tx side.
//  - Collect buffer is a FRAME_BYTES x DBITS register array with a byte-slot write enable.
// TESTING
//  1. Reset, frame_len=16, bytes 0x00..0x0F -> frame_out=0x0F0E..0100, frame_valid 2 clk after last strobe.
//  2. frame_len=4, bytes A1 B2 C3 D4, ready=1 -> frame_out low 32b=0xD4C3B2A1, rest 0; valid for 1 clk.
//  3. TIMEOUT_CYCLES=50: 3 bytes then 60 idle clk -> timeout_err=1, no frame; next 16 bytes -> clean frame.
//  4. ready=0, two full frames sent -> first frame held unchanged, overrun=1; clr_err -> overrun=0.
//  5. Frame completes the same cycle the held frame is accepted -> new frame loaded, overrun stays 0.
//  6. rst_n pulled low after 7 bytes -> byte_count=0, frame_valid=0 asynchronously; next 16 bytes frame correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: assembler state encoding and the default character width.
package uart_pkg;

    localparam int DBITS_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        DONE    = ST_DONE
    } asm_state_t;

endpackage

// File: rtl/frame_out_buf.sv
// One-deep valid/ready register stage. A load is taken when the stage is empty
// or draining in the same cycle; otherwise it is refused and flagged as a drop.
module frame_out_buf #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         drop
);

    assign drop = load && valid && !ready;

    // Hold the frame while the consumer stalls; replace it or empty it on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load && (!valid || ready)) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Packs the UART receive byte stream into fixed-layout frames with a runtime
// length, an inter-byte abort timer and a one-deep output buffer.
module uart_frame_assembler
    import uart_pkg::*;
#(
    parameter int DBITS          = DBITS_DEFAULT,
    parameter int FRAME_BYTES    = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DBITS-1:0]             byte_in,
    input  logic                         byte_valid,
    input  logic [CNT_W-1:0]             frame_len,
    output logic [FRAME_BYTES*DBITS-1:0] frame_out,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [CNT_W-1:0]             byte_count,
    output logic                         overrun,
    output logic                         timeout_err,
    input  logic                         clr_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(FRAME_BYTES);

    asm_state_t state, state_n;

    logic [CNT_W-1:0]             len_q;
    logic [CNT_W-1:0]             len_in;
    logic [CNT_W-1:0]             bc, bc_n;
    logic [TW-1:0]                tcnt, tcnt_n;
    logic                         wr_en;
    logic [CNT_W-1:0]             wr_slot;
    logic                         latch_len;
    logic                         load;
    logic                         abort;
    logic                         drop;
    logic [DBITS-1:0]             mem [FRAME_BYTES];
    logic [FRAME_BYTES*DBITS-1:0] frame_data;

    assign len_in     = (frame_len == '0 || frame_len > MAX_LEN) ? MAX_LEN : frame_len;
    assign byte_count = bc;

    // State, byte counter, timeout counter and latched length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            bc    <= '0;
            tcnt  <= '0;
            len_q <= '0;
        end else begin
            state <= state_n;
            bc    <= bc_n;
            tcnt  <= tcnt_n;
            if (latch_len) begin
                len_q <= len_in;
            end
        end
    end

    // Next-state and datapath control; a byte seen in IDLE or DONE always starts a new frame.
    always_comb begin
        state_n   = state;
        bc_n      = bc;
        tcnt_n    = '0;
        wr_en     = 1'b0;
        wr_slot   = bc;
        latch_len = 1'b0;
        load      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
            end
            COLLECT: begin
                if (byte_valid) begin
                    wr_en = 1'b1;
                    bc_n  = bc + 1'b1;
                    if (bc == len_q - 1'b1) begin
                        state_n = DONE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (tcnt == TMAX) begin
                        abort   = 1'b1;
                        bc_n    = '0;
                        state_n = IDLE;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            DONE: begin
                load    = 1'b1;
                bc_n    = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                bc_n    = '0;
            end
        endcase
        if (byte_valid && (state == IDLE || state == DONE)) begin
            latch_len = 1'b1;
            wr_en     = 1'b1;
            wr_slot   = '0;
            bc_n      = CNT_W'(1);
            state_n   = (len_in == CNT_W'(1)) ? DONE : COLLECT;
        end
    end

    // Collect buffer: each slot is written only when its write enable matches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (wr_en && wr_slot == CNT_W'(k)) begin
                    mem[k] <= byte_in;
                end
            end
        end
    end

    // Pack the collect buffer, forcing slots at or beyond the frame length to zero.
    always_comb begin
        frame_data = '0;
        for (int k = 0; k < FRAME_BYTES; k++) begin
            frame_data[k*DBITS +: DBITS] = (CNT_W'(k) < len_q) ? mem[k] : '0;
        end
    end

    // Sticky error flags; a new event in the same cycle beats the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    frame_out_buf #(
        .W(FRAME_BYTES*DBITS)
    ) u_out_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (frame_data),
        .ready     (frame_ready),
        .valid     (frame_valid),
        .data      (frame_out),
        .drop      (drop)
    );

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Randomised and directed bench for uart_frame_assembler against a queue-based frame model.
module tb_uart_frame_assembler;

    localparam int DBITS          = 8;
    localparam int FRAME_BYTES    = 16;
    localparam int TIMEOUT_CYCLES = 50;
    localparam int CNT_W          = 8;
    localparam int W              = FRAME_BYTES * DBITS;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [DBITS-1:0] byte_in;
    logic             byte_valid;
    logic [CNT_W-1:0] frame_len;
    logic [W-1:0]     frame_out;
    logic             frame_valid;
    logic             frame_ready;
    logic [CNT_W-1:0] byte_count;
    logic             overrun;
    logic             timeout_err;
    logic             clr_err;

    int n_tests  = 0;
    int n_failed = 0;

    // Reference model: bytes of the frame in progress, the completed frame waiting
    // one cycle to reach the output buffer, and the output buffer itself.
    logic [7:0]   cur[$];
    int           cur_len;
    int           idle_cnt;
    bit           pend;
    logic [W-1:0] pend_data;
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_ovr;
    bit           m_tmo;

    uart_frame_assembler #(
        .DBITS          (DBITS),
        .FRAME_BYTES    (FRAME_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .frame_len   (frame_len),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .byte_count  (byte_count),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clr_err     (clr_err)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        cur.delete();
        cur_len   = 0;
        idle_cnt  = 0;
        pend      = 0;
        pend_data = '0;
        m_valid   = 0;
        m_data    = '0;
        m_ovr     = 0;
        m_tmo     = 0;
    endtask

    task automatic modelStep(input logic bv, input logic [7:0] b, input logic [7:0] flen,
                             input logic rdy, input logic clr);
        bit ovr_set = 0;
        bit tmo_set = 0;
        if (pend) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_data  = pend_data;
            end else begin
                ovr_set = 1;
            end
            pend = 0;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        if (bv) begin
            if (cur.size() == 0) begin
                cur_len = (flen == 0 || int'(flen) > FRAME_BYTES) ? FRAME_BYTES : int'(flen);
            end
            cur.push_back(b);
            idle_cnt = 0;
            if (cur.size() == cur_len) begin
                pend_data = '0;
                foreach (cur[i]) pend_data[i*8 +: 8] = cur[i];
                pend = 1;
                cur.delete();
            end
        end else if (cur.size() != 0) begin
            idle_cnt++;
            if (idle_cnt == TIMEOUT_CYCLES) begin
                cur.delete();
                idle_cnt = 0;
                tmo_set  = 1;
            end
        end
        m_ovr = ovr_set || (m_ovr && !clr);
        m_tmo = tmo_set || (m_tmo && !clr);
    endtask

    task automatic applyStimulus(input logic bv, input logic [7:0] b, input logic [7:0] flen,
                                 input logic rdy, input logic clr);
        byte_valid  = bv;
        byte_in     = b;
        frame_len   = flen;
        frame_ready = rdy;
        clr_err     = clr;
        @(posedge clk);
        #1;
        modelStep(bv, b, flen, rdy, clr);
        checkOutput("frame_valid", W'(frame_valid), W'(m_valid));
        checkOutput("frame_out", frame_out, m_data);
        checkOutput("overrun", W'(overrun), W'(m_ovr));
        checkOutput("timeout_err", W'(timeout_err), W'(m_tmo));
        if (!pend) begin
            checkOutput("byte_count", W'(byte_count), W'(cur.size()));
        end
    endtask

    task automatic sendBytes(input int n, input int base, input logic [7:0] flen, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 8'(base + i), flen, rdy, 1'b0);
        end
    endtask

    task automatic idleCycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 8'd16, rdy, 1'b0);
        end
    endtask

    task automatic asyncReset();
        byte_valid = 1'b0;
        clr_err    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_frame_valid", W'(frame_valid), '0);
        checkOutput("rst_byte_count", W'(byte_count), '0);
        checkOutput("rst_frame_out", frame_out, '0);
        checkOutput("rst_overrun", W'(overrun), '0);
        checkOutput("rst_timeout_err", W'(timeout_err), '0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        byte_in     = '0;
        byte_valid  = 1'b0;
        frame_len   = 8'd16;
        frame_ready = 1'b0;
        clr_err     = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_frame_valid", W'(frame_valid), '0);
        checkOutput("reset_frame_out", frame_out, '0);
        checkOutput("reset_byte_count", W'(byte_count), '0);
        checkOutput("reset_overrun", W'(overrun), '0);
        checkOutput("reset_timeout_err", W'(timeout_err), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-length frame of 0x00..0x0F, held by ready=0 to observe latency.
        sendBytes(16, 0, 8'd16, 1'b0);
        checkOutput("t1_valid_after_1clk", W'(frame_valid), '0);
        applyStimulus(1'b0, 8'h00, 8'd16, 1'b0, 1'b0);
        checkOutput("t1_valid_after_2clk", W'(frame_valid), W'(1));
        checkOutput("t1_frame", frame_out, 128'h0F0E0D0C0B0A09080706050403020100);
        idleCycles(2, 1'b1);

        // Short frame with ready held high: valid for exactly one cycle.
        applyStimulus(1'b1, 8'hA1, 8'd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hB2, 8'd9, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hC3, 8'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hD4, 8'd1, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'd4, 1'b1, 1'b0);
        checkOutput("t2_frame", frame_out, W'(32'hD4C3B2A1));
        checkOutput("t2_valid", W'(frame_valid), W'(1));
        applyStimulus(1'b0, 8'h00, 8'd4, 1'b1, 1'b0);
        checkOutput("t2_valid_drop", W'(frame_valid), '0);

        // Partial frame aborted by the inter-byte timeout, then a clean frame.
        sendBytes(3, 8'h50, 8'd16, 1'b1);
        checkOutput("t3_partial_count", W'(byte_count), W'(3));
        idleCycles(60, 1'b1);
        checkOutput("t3_timeout_err", W'(timeout_err), W'(1));
        checkOutput("t3_no_frame", W'(frame_valid), '0);
        sendBytes(16, 8'h60, 8'd16, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("t3_clean_frame", frame_out, 128'h6F6E6D6C6B6A69686766656463626160);
        idleCycles(2, 1'b1);

        // Two frames against a stalled consumer: first held, second dropped.
        sendBytes(16, 8'h20, 8'd16, 1'b0);
        sendBytes(16, 8'h30, 8'd16, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("t4_held_frame", frame_out, 128'h2F2E2D2C2B2A29282726252423222120);
        checkOutput("t4_overrun", W'(overrun), W'(1));
        applyStimulus(1'b0, 8'h00, 8'd16, 1'b0, 1'b1);
        checkOutput("t4_overrun_clr", W'(overrun), '0);
        checkOutput("t4_timeout_clr", W'(timeout_err), '0);

        // New frame completes in the same cycle the held frame is accepted.
        sendBytes(16, 8'h80, 8'd16, 1'b0);
        applyStimulus(1'b0, 8'h00, 8'd16, 1'b1, 1'b0);
        checkOutput("t5_new_frame", frame_out, 128'h8F8E8D8C8B8A89888786858483828180);
        checkOutput("t5_valid", W'(frame_valid), W'(1));
        checkOutput("t5_no_overrun", W'(overrun), '0);
        idleCycles(2, 1'b1);

        // Asynchronous reset in the middle of a frame.
        sendBytes(7, 8'h90, 8'd16, 1'b1);
        asyncReset();
        sendBytes(16, 8'hC0, 8'd16, 1'b0);
        idleCycles(1, 1'b0);
        checkOutput("t6_frame_after_reset", frame_out, 128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0);
        idleCycles(2, 1'b1);

        // Randomised traffic: dense, sparse (timeouts) and mixed phases.
        for (int blk = 0; blk < 60; blk++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int c = 0; c < 50; c++) begin
                logic bv;
                logic rdy;
                if (mode == 0) begin
                    bv = ($urandom_range(0, 9) < 7);
                end else if (mode == 1) begin
                    bv = ($urandom_range(0, 99) < 3);
                end else begin
                    bv = 1'($urandom_range(0, 1));
                end
                rdy = (mode == 2) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
                applyStimulus(bv, 8'($urandom), 8'($urandom_range(0, 20)), rdy,
                              ($urandom_range(0, 31) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
